// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg
//   Shared types and helpers for the HI/LO multiply sequencer.
//   - state_t     : sequencer states (IDLE, CALC)
//   - DEF_WIDTH   : default operand width
//   - clog2()     : counter width helper, never returns less than 1
package mul_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 32;

  // Width of a down-counter that must hold n-1. A 1-cycle window still
  // needs a 1-bit register so the counter port never collapses to zero bits.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mul.sv
// mul
//   Combinational unsigned multiplier. Timed as a multicycle path by the
//   sequencer, which holds its inputs stable for the whole window.
//   Ports:
//     x  in   WIDTH     unsigned multiplicand
//     y  in   WIDTH     unsigned multiplier
//     p  out  2*WIDTH   full-width unsigned product
module mul
  import mul_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] p
);

  assign p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};

endmodule

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl
//   Multi-cycle MULT/MULTU sequencer that owns the HI/LO registers.
//   Operands are latched as sign-magnitude, the unsigned `mul` gets a fixed
//   MUL_CYCLES window, then the product sign is restored and HI/LO commit.
//   MTHI/MTLO writes are accepted in any state.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     start      in   1      begin a multiply (honoured in IDLE only)
//     op_signed  in   1      1 = MULT, 0 = MULTU
//     a, b       in   WIDTH  operands, sampled with start
//     cancel     in   1      flush: abort the in-flight multiply
//     mthi_we    in   1      write wdata into HI
//     mtlo_we    in   1      write wdata into LO
//     wdata      in   WIDTH  MTHI/MTLO data
//     busy       out  1      multiply in flight
//     done       out  1      HI/LO committed on the preceding edge
//     hi, lo     out  WIDTH  architectural HI/LO
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; done may be high for one cycle after CALC
//   CALC  | mul window running; cnt counts down to terminal count 0
module mul_hilo_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = clog2(MUL_CYCLES);
  localparam int PW = 2 * WIDTH;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg;
  logic [PW-1:0]    prod;

  mul #(.WIDTH(WIDTH)) u_mul (
    .x (mag_a),
    .y (mag_b),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;

      // MT writes land first so a completing product, assigned later in
      // this block, overrides them.
      if (mthi_we) begin
        hi <= wdata;
      end
      if (mtlo_we) begin
        lo <= wdata;
      end

      case (state)
        IDLE: begin
          if (start) begin
            // -2^(W-1) negates to itself, which is its correct unsigned magnitude.
            mag_a <= (op_signed && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
            mag_b <= (op_signed && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
            neg   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt   <= CW'(MUL_CYCLES - 1);
            state <= CALC;
            busy  <= 1'b1;
          end
        end

        CALC: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            {hi, lo} <= neg ? ({PW{1'b0}} - prod) : prod;
            done     <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
module tb_mul_hilo_ctrl;

  localparam int W  = 32;
  localparam int MC = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         mthi_we;
  logic         mtlo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  mul_hilo_ctrl #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_signed (op_signed),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .mthi_we   (mthi_we),
    .mtlo_we   (mtlo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-precision product truncated to 64 bits.
  function automatic logic [63:0] ref_prod(input logic sg, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic signed [63:0] sx, sy;
    if (sg) begin
      sx = $signed({{32{x[W-1]}}, x});
      sy = $signed({{32{y[W-1]}}, y});
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits out the busy window from the first CALC cycle, then checks the
  // window length, the done pulse and the committed HI/LO.
  task automatic wait_done(input logic [63:0] exp, input string tag);
    int cycles;
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      cycles++;
      step();
      start = 1'b0;
    end
    chk({tag, "_busy_cycles"}, 64'(cycles), 64'(MC));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  task automatic launch(input logic sg, input logic [W-1:0] x, input logic [W-1:0] y);
    start     = 1'b1;
    op_signed = sg;
    a         = x;
    b         = y;
    step();
    start = 1'b0;
  endtask

  task automatic run_mul(input logic sg, input logic [W-1:0] x, input logic [W-1:0] y,
                         input string tag);
    launch(sg, x, y);
    wait_done(ref_prod(sg, x, y), tag);
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    logic         rs;
    logic [63:0]  exp;

    rst_n = 1'b0; start = 1'b0; op_signed = 1'b0; a = '0; b = '0;
    cancel = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
    step();
    step();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    step();

    // Directed products, with hand-derived constants
    launch(1'b0, 32'd9, 32'd12);
    chk("t1_busy_first", 64'(busy), 64'd1);
    wait_done(64'h00000000_0000006C, "t1_multu");
    step();
    chk("t1_done_clear", 64'(done), 64'd0);

    launch(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE);
    wait_done(64'hFFFFFFFC_00000004, "t2_multu_big");
    launch(1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE);
    wait_done(64'h00000000_00000004, "t2_mult_neg2sq");
    launch(1'b1, 32'h80000000, 32'h80000000);
    wait_done(64'h40000000_00000000, "t3_mult_min");
    launch(1'b1, 32'hFFFFFFFD, 32'd7);
    wait_done(64'hFFFFFFFF_FFFFFFEB, "t3_mult_m3x7");
    launch(1'b1, 32'd0, 32'hFFFFFFFB);
    wait_done(64'd0, "t3_mult_zero_neg");
    launch(1'b0, 32'h80000000, 32'd3);
    wait_done(64'h00000001_80000000, "t3_multu_min");

    // Randomized operands against the arithmetic reference; each new
    // start lands in the previous done cycle (back-to-back issue).
    for (int i = 0; i < 12; i++) begin
      rx = $urandom;
      ry = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i == 0) rx = 32'h80000000;
      if (i == 1) ry = 32'hFFFFFFFF;
      run_mul(rs, rx, ry, $sformatf("rand%0d", i));
    end
    step();

    // Cancel in the second CALC cycle
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'd5;
    step();
    mtlo_we = 1'b1; mthi_we = 1'b0; wdata = 32'd6;
    step();
    mtlo_we = 1'b0;
    chk("t4_mt_setup", {hi, lo}, {32'd5, 32'd6});
    launch(1'b0, 32'd1000, 32'd1000);
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("t4_cancel_busy", 64'(busy), 64'd0);
    chk("t4_cancel_done", 64'(done), 64'd0);
    chk("t4_cancel_hilo", {hi, lo}, {32'd5, 32'd6});
    for (int i = 0; i < MC + 2; i++) begin
      step();
      chk("t4_no_late_done", 64'(done), 64'd0);
    end
    chk("t4_hilo_kept", {hi, lo}, {32'd5, 32'd6});

    // Start while busy is ignored; then back-to-back in the done cycle
    launch(1'b0, 32'd100, 32'd3);
    start = 1'b1; a = 32'd1; b = 32'd1;
    wait_done(64'd300, "t5_ignore_start");
    launch(1'b1, 32'hFFFFFFF9, 32'hFFFFFFF9);
    wait_done(64'd49, "t5_back_to_back");
    step();

    // MTHI in the completion cycle loses to the product
    launch(1'b0, 32'hFFFFFFFF, 32'd2);
    for (int i = 0; i < MC - 1; i++) step();
    chk("t6_last_cycle_busy", 64'(busy), 64'd1);
    mthi_we = 1'b1; wdata = 32'h0000AAAA;
    step();
    mthi_we = 1'b0;
    chk("t6_product_wins_done", 64'(done), 64'd1);
    chk("t6_product_wins", {hi, lo}, 64'h00000001_FFFFFFFE);

    // MTLO while idle
    mtlo_we = 1'b1; wdata = 32'h12345678;
    step();
    mtlo_we = 1'b0;
    chk("t6_mtlo_idle", {hi, lo}, 64'h00000001_12345678);

    // MT write together with start; operands already latched
    mthi_we = 1'b1; wdata = 32'hDEAD0001;
    launch(1'b0, 32'd6, 32'd7);
    mthi_we = 1'b0;
    chk("t6_mt_with_start", {hi, lo}, 64'hDEAD0001_12345678);
    chk("t6_mt_with_start_busy", 64'(busy), 64'd1);
    wait_done(64'd42, "t6_mt_start_mul");
    step();

    // Asynchronous reset in the middle of CALC
    launch(1'b1, 32'hFFFFFFFD, 32'd7);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", 64'(busy), 64'd0);
    chk("t4_rst_done", 64'(done), 64'd0);
    chk("t4_rst_hilo", {hi, lo}, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < MC + 2; i++) begin
      step();
      chk("t4_rst_no_done", 64'(done), 64'd0);
    end
    exp = 64'd0;
    chk("t4_rst_hilo_after", {hi, lo}, exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
